multiplier_sequencer: RTL and testbench

//   Front-end sequencer for the shift-and-add multiplier. Accepts operand pairs over a

---
 rtl/multiplier_sequencer.sv | 153 +++++++++++++++
 tb/tb_multiplier_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_sequencer.sv
// multiplier_sequencer
//   Front-end sequencer for the shift-and-add multiplier. It accepts an operand
//   pair over a valid/ready handshake and drives the pair onto mult_*. It then
//   pulses mult_start and waits for mult_ready. When the result arrives, it
//   captures the 2*WIDTH product and pulses mult_clear. That pulse returns the
//   multiplier, which holds in DONE, to idle. Finally the sequencer presents the
//   product downstream over valid/ready.
//
//   Optional feature macro: MULT_SEQ_TIMEOUT_EN
//     When defined, a WAIT cycle counter aborts after TIMEOUT cycles without
//     mult_ready. On abort it sets the sticky error flag and forces a zero
//     product. When undefined, WAIT waits indefinitely and error is tied to 0.
//
// Ports
//   clock, reset                 single clock, synchronous active-high reset
//   in_valid/in_ready            operand handshake (in_ready high only in IDLE)
//   in_multiplicand/multiplier   operands A and B
//   mult_multiplicand/multiplier registered operands to the multiplier datapath
//   mult_start                   one-cycle start pulse
//   mult_ready/mult_product      multiplier result (level, held while in DONE)
//   mult_clear                   one-cycle pulse; ORed into the multiplier reset
//   out_valid/out_ready          result handshake
//   out_product                  captured product, stable while out_valid
//   done_count                   results delivered, wraps modulo 2**COUNT_WIDTH
//   error                        sticky timeout flag
module multiplier_sequencer #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned TIMEOUT     = 4 * WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_multiplicand,
  input  logic [WIDTH-1:0]       in_multiplier,
  output logic [WIDTH-1:0]       mult_multiplicand,
  output logic [WIDTH-1:0]       mult_multiplier,
  output logic                   mult_start,
  input  logic                   mult_ready,
  input  logic [2*WIDTH-1:0]     mult_product,
  output logic                   mult_clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out_product,
  output logic [COUNT_WIDTH-1:0] done_count,
  output logic                   error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CLEAR,
    S_HOLD
  } state_t;

  state_t state;

  // A zero TIMEOUT would make the abort path meaningless.
  if (TIMEOUT == 0) begin : g_timeout_check
    $error("multiplier_sequencer: TIMEOUT must be nonzero");
  end

`ifdef MULT_SEQ_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  // wait_cnt holds the number of WAIT cycles already completed. Expiry
  // happens in the TIMEOUT-th WAIT cycle, when the count reaches TIMEOUT-1.
  logic [TW-1:0] wait_cnt;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= S_IDLE;
      in_ready          <= 1'b1;
      mult_multiplicand <= '0;
      mult_multiplier   <= '0;
      mult_start        <= 1'b0;
      mult_clear        <= 1'b0;
      out_valid         <= 1'b0;
      out_product       <= '0;
      done_count        <= '0;
`ifdef MULT_SEQ_TIMEOUT_EN
      wait_cnt          <= '0;
      error             <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            mult_multiplicand <= in_multiplicand;
            mult_multiplier   <= in_multiplier;
            mult_start        <= 1'b1;
            in_ready          <= 1'b0;
            state             <= S_LAUNCH;
          end
        end

        // mult_ready may still show the previous result's DONE level in this
        // cycle, so it is deliberately not looked at here.
        S_LAUNCH: begin
          mult_start <= 1'b0;
`ifdef MULT_SEQ_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
          state      <= S_WAIT;
        end

        S_WAIT: begin
          if (mult_ready) begin
            out_product <= mult_product;
            mult_clear  <= 1'b1;
            state       <= S_CLEAR;
          end
`ifdef MULT_SEQ_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            out_product <= '0;
            error       <= 1'b1;
            mult_clear  <= 1'b1;
            state       <= S_CLEAR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        S_CLEAR: begin
          mult_clear <= 1'b0;
          out_valid  <= 1'b1;
          state      <= S_HOLD;
        end

        S_HOLD: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            done_count <= done_count + 1'b1;
            in_ready   <= 1'b1;
            state      <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Testbench for multiplier_sequencer. It contains a behavioural 9-cycle
// multiplier model, randomized operand traffic, and randomized downstream
// backpressure. A scoreboard queue holds the expected products. A monitor
// tracks the expected handshake timing at transaction level.
module tb_multiplier_sequencer;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned COUNT_WIDTH = 16;
  localparam int unsigned TIMEOUT     = 32;
  localparam int unsigned MULT_LAT    = 9;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_multiplicand = '0;
  logic [WIDTH-1:0]       in_multiplier = '0;
  logic [WIDTH-1:0]       mult_multiplicand;
  logic [WIDTH-1:0]       mult_multiplier;
  logic                   mult_start;
  logic                   mult_ready = 1'b0;
  logic [2*WIDTH-1:0]     mult_product = '0;
  logic                   mult_clear;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [2*WIDTH-1:0]     out_product;
  logic [COUNT_WIDTH-1:0] done_count;
  logic                   error;

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [2*WIDTH-1:0] sb[$];
  bit                 stuck = 1'b0;
  int unsigned        hold_cnt = 0;

  multiplier_sequencer #(
    .WIDTH(WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_multiplicand(in_multiplicand),
    .in_multiplier(in_multiplier),
    .mult_multiplicand(mult_multiplicand),
    .mult_multiplier(mult_multiplier),
    .mult_start(mult_start),
    .mult_ready(mult_ready),
    .mult_product(mult_product),
    .mult_clear(mult_clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_product(out_product),
    .done_count(done_count),
    .error(error)
  );

  always #5 clock = ~clock;

  // Behavioural multiplier. It latches the operands on mult_start and raises
  // ready MULT_LAT cycles later. It holds ready and the product until
  // mult_clear or reset. While stuck is set it never finishes.
  logic [WIDTH-1:0] m_a, m_b;
  bit               m_busy = 1'b0;
  int unsigned      m_cnt = 0;

  always @(posedge clock) begin
    if (reset || mult_clear) begin
      m_busy       <= 1'b0;
      m_cnt        <= 0;
      mult_ready   <= 1'b0;
      mult_product <= '0;
    end else if (mult_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 0;
      m_a    <= mult_multiplicand;
      m_b    <= mult_multiplier;
    end else if (m_busy && !stuck) begin
      if (m_cnt == MULT_LAT - 1) begin
        mult_ready   <= 1'b1;
        mult_product <= (2*WIDTH)'(m_a) * (2*WIDTH)'(m_b);
        m_busy       <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream sink with random backpressure. A nonzero hold_cnt forces
  // out_ready low for that many cycles of out_valid.
  initial begin
    forever begin
      @(negedge clock);
      if (out_valid && hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor and reference model. It samples 1 time unit after each rising
  // edge. At that point the inputs still hold the values the edge just
  // sampled, and the outputs show the new cycle.
  bit                   e_ir = 1'b1, e_start = 1'b0, e_clear = 1'b0, e_ov = 1'b0, e_err = 1'b0;
  logic [COUNT_WIDTH-1:0] e_cnt = '0;
  bit                   in_wait = 1'b0;
  int unsigned          wcnt = 0;
  logic                 rdy_q = 1'b0;

  initial begin
    bit acc, hs, n_clear;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        e_ir = 1'b1; e_start = 1'b0; e_clear = 1'b0; e_ov = 1'b0; e_err = 1'b0;
        e_cnt = '0; in_wait = 1'b0; wcnt = 0;
        sb.delete();
      end else begin
        acc     = in_valid && e_ir;
        hs      = e_ov && out_ready;
        n_clear = 1'b0;
        if (in_wait) begin
          if (rdy_q === 1'b1) begin
            n_clear = 1'b1;
            in_wait = 1'b0;
          end else begin
            wcnt++;
`ifdef MULT_SEQ_TIMEOUT_EN
            if (wcnt == TIMEOUT) begin
              n_clear = 1'b1;
              in_wait = 1'b0;
              e_err   = 1'b1;
              if (sb.size() > 0) sb[sb.size()-1] = '0;
            end
`endif
          end
        end
        if (e_start) begin
          in_wait = 1'b1;
          wcnt    = 0;
        end
        if (hs) begin
          if (sb.size() > 0) void'(sb.pop_front());
          e_cnt = e_cnt + 1'b1;
        end
        e_ov    = e_clear || (e_ov && !out_ready);
        e_ir    = hs ? 1'b1 : (acc ? 1'b0 : e_ir);
        e_start = acc;
        e_clear = n_clear;
      end
      rdy_q = mult_ready;

      chk("in_ready",   32'(in_ready),   32'(e_ir));
      chk("mult_start", 32'(mult_start), 32'(e_start));
      chk("mult_clear", 32'(mult_clear), 32'(e_clear));
      chk("out_valid",  32'(out_valid),  32'(e_ov));
      chk("done_count", 32'(done_count), 32'(e_cnt));
      chk("error",      32'(error),      32'(e_err));
      if (e_ov) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_product: got 0x%0h with no expected entry at %0t", out_product, $time);
        end else begin
          chk("out_product", 32'(out_product), 32'(sb[0]));
        end
      end
    end
  end

  // Presents an operand pair, called on a falling edge. When keep is set,
  // in_valid stays high after the accept so that the sequencer has to
  // ignore it until it is back in IDLE.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit keep);
    int unsigned        n;
    logic [2*WIDTH-1:0] p;
    n = 0;
    in_multiplicand = a;
    in_multiplier   = b;
    in_valid        = 1'b1;
    while (in_ready !== 1'b1) begin
      @(negedge clock);
      n++;
      if (n > 400) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: in_ready never rose for A=%0d B=%0d", a, b);
        in_valid = 1'b0;
        return;
      end
    end
    p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    sb.push_back(p);
    @(negedge clock);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0) begin
      @(negedge clock);
      n++;
      if (n > 2000) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout: %0d results still pending", sb.size());
        sb.delete();
        return;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int unsigned nops;
    bit          keep;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Directed products and boundary operands.
    do_op(8'd13, 8'd11, 1'b0);
    wait_drain();
    do_op(8'd255, 8'd255, 1'b0);
    do_op(8'd0, 8'd200, 1'b0);

    // Downstream stall of 5 cycles while the result is held.
    hold_cnt = 5;
    do_op(8'd77, 8'd3, 1'b0);

    // in_valid held high across whole operations.
    do_op(8'd9, 8'd9, 1'b1);
    do_op(8'd200, 8'd100, 1'b1);
    do_op(8'd5, 8'd6, 1'b0);
    wait_drain();

    // Reset while waiting on the multiplier.
    stuck = 1'b1;
    do_op(8'd21, 8'd4, 1'b0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    stuck = 1'b0;
    @(negedge clock);

    // Multiplier silent for a long stretch. With the timeout feature this
    // aborts to a zero product; without it the result arrives late.
    stuck = 1'b1;
    do_op(8'd3, 8'd7, 1'b0);
    repeat (60) @(negedge clock);
    stuck = 1'b0;
    wait_drain();

    // Randomized traffic.
    nops = 40;
    for (int i = 0; i < 40; i++) begin
      keep = (i != nops - 1) && ($urandom_range(0, 3) == 0);
      do_op(WIDTH'($urandom), WIDTH'($urandom), keep);
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    in_valid = 1'b0;
    wait_drain();
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
